iobuf_bank: RTL

// - Parametrised N-channel controller for Bus Pirate I/O pins behind external

---
 rtl/iobuf_bank_pkg.sv | 26 ++
 rtl/iobuf_bank_if.sv | 33 +++
 rtl/iobuf_sync2.sv | 25 ++
 rtl/iobuf_bank.sv | 172 +++++++++++++++++
 4 files changed

// File: rtl/iobuf_bank_pkg.sv
// Shared definitions for the I/O buffer bank: sequencer state encodings,
// direction constants and the per-channel configuration record.
package iobuf_bank_pkg;

    localparam logic [1:0] ST_IDLE    = 2'd0;
    localparam logic [1:0] ST_DRV_OFF = 2'd1;
    localparam logic [1:0] ST_BUF_SET = 2'd2;
    localparam logic [1:0] ST_DRV_ON  = 2'd3;

    localparam logic DIR_IN  = 1'b0;
    localparam logic DIR_OUT = 1'b1;

    typedef struct packed {
        logic en;
        logic dir;
        logic od;
    } chan_cfg_t;

    localparam chan_cfg_t CFG_RESET = '{en: 1'b0, dir: DIR_IN, od: 1'b0};

    // Open-drain channels only enable the FPGA pad when pulling low.
    function automatic logic pad_oe_calc(input chan_cfg_t c, input logic d);
        return c.en & (c.dir == DIR_OUT) & (c.od ? ~d : 1'b1);
    endfunction

endpackage

// File: rtl/iobuf_bank_if.sv
// Configuration handshake, per-channel data and pad/buffer control bundle
// between a requester (master) and the buffer bank (slave).
interface iobuf_bank_if #(
    parameter int NCH = 4
);
    localparam int CW = (NCH > 1) ? $clog2(NCH) : 1;

    logic           cfg_valid;
    logic           cfg_ready;
    logic [CW-1:0]  cfg_chan;
    logic           cfg_en;
    logic           cfg_dir;
    logic           cfg_od;
    logic [NCH-1:0] dout;
    logic [NCH-1:0] din_sync;
    logic [NCH-1:0] pad_oe;
    logic [NCH-1:0] pad_dout;
    logic [NCH-1:0] pad_din;
    logic [NCH-1:0] buf_oe;
    logic [NCH-1:0] buf_dir;
    logic [NCH-1:0] buf_od;

    modport master (
        output cfg_valid, cfg_chan, cfg_en, cfg_dir, cfg_od, dout, pad_din,
        input  cfg_ready, din_sync, pad_oe, pad_dout, buf_oe, buf_dir, buf_od
    );

    modport slave (
        input  cfg_valid, cfg_chan, cfg_en, cfg_dir, cfg_od, dout, pad_din,
        output cfg_ready, din_sync, pad_oe, pad_dout, buf_oe, buf_dir, buf_od
    );

endinterface

// File: rtl/iobuf_sync2.sv
// Two-flop synchroniser bringing asynchronous pad inputs into the clk domain.
module iobuf_sync2 #(
    parameter int W = 1
) (
    input  logic         clk,
    input  logic         rst,
    input  logic [W-1:0] d_i,
    output logic [W-1:0] q_o
);
    logic [W-1:0] meta_q;
    logic [W-1:0] sync_q;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            meta_q <= '0;
            sync_q <= '0;
        end else begin
            meta_q <= d_i;
            sync_q <= meta_q;
        end
    end

    assign q_o = sync_q;

endmodule

// File: rtl/iobuf_bank.sv
// N-channel pad/buffer controller: registered pad drive, synchronised inputs and
// a break-before-make sequencer for direction and open-drain changes.
module iobuf_bank
    import iobuf_bank_pkg::*;
#(
    parameter int NCH    = 4,
    parameter int SETTLE = 8
) (
    input logic         clk,
    input logic         rst,
    iobuf_bank_if.slave bus
);
    localparam int CW  = (NCH > 1) ? $clog2(NCH) : 1;
    localparam int CTW = $clog2(SETTLE + 1);
    localparam logic [CTW-1:0] CNT_LOAD = CTW'(SETTLE - 1);
    localparam logic [CW:0]    NCH_L    = (CW + 1)'(NCH);

    logic [1:0]          state_q, state_d;
    logic [CTW-1:0]      cnt_q, cnt_d;
    logic                ready_q, ready_d;
    logic [CW-1:0]       seq_ch_q, seq_ch_d;
    chan_cfg_t           seq_cfg_q, seq_cfg_d;
    chan_cfg_t [NCH-1:0] cfg_q, cfg_d;
    logic [NCH-1:0]      pad_oe_q, pad_oe_d;
    logic [NCH-1:0]      pad_dout_q, pad_dout_d;
    logic [NCH-1:0]      buf_oe_q, buf_oe_d;
    logic [NCH-1:0]      buf_dir_q, buf_dir_d;
    logic [NCH-1:0]      buf_od_q, buf_od_d;
    logic [NCH-1:0]      din_sync_w;

    logic cur_dir, cur_od;
    logic accept, in_range, same_mode, fast_acc, slow_acc;
    logic buf_wr, commit;

    always_comb begin
        cur_dir = DIR_IN;
        cur_od  = 1'b0;
        for (int i = 0; i < NCH; i++) begin
            if (bus.cfg_chan == CW'(i)) begin
                cur_dir = cfg_q[i].dir;
                cur_od  = cfg_q[i].od;
            end
        end
    end

    // Out-of-range channels are accepted but touch nothing.
    assign accept    = bus.cfg_valid & ready_q;
    assign in_range  = ({1'b0, bus.cfg_chan} < NCH_L);
    assign same_mode = (cur_dir == bus.cfg_dir) && (cur_od == bus.cfg_od);
    assign fast_acc  = accept & in_range & same_mode;
    assign slow_acc  = accept & in_range & ~same_mode;

    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        seq_ch_d  = seq_ch_q;
        seq_cfg_d = seq_cfg_q;
        buf_wr    = 1'b0;
        commit    = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (slow_acc) begin
                    state_d   = ST_DRV_OFF;
                    cnt_d     = CNT_LOAD;
                    seq_ch_d  = bus.cfg_chan;
                    seq_cfg_d = '{en: bus.cfg_en, dir: bus.cfg_dir, od: bus.cfg_od};
                end
            end
            ST_DRV_OFF: begin
                if (cnt_q == '0) begin
                    state_d = ST_BUF_SET;
                    cnt_d   = CNT_LOAD;
                    buf_wr  = 1'b1;
                end else begin
                    cnt_d = cnt_q - CTW'(1);
                end
            end
            ST_BUF_SET: begin
                if (cnt_q == '0) begin
                    state_d = ST_DRV_ON;
                    cnt_d   = CNT_LOAD;
                end else begin
                    cnt_d = cnt_q - CTW'(1);
                end
            end
            ST_DRV_ON: begin
                state_d = ST_IDLE;
                commit  = 1'b1;
            end
            default: state_d = ST_IDLE;
        endcase
        // Ready comes back one cycle after the return to IDLE.
        ready_d = (state_q == ST_IDLE) & ~slow_acc;
    end

    always_comb begin
        cfg_d      = cfg_q;
        buf_oe_d   = buf_oe_q;
        buf_dir_d  = buf_dir_q;
        buf_od_d   = buf_od_q;
        pad_oe_d   = '0;
        pad_dout_d = '0;
        for (int i = 0; i < NCH; i++) begin
            if (fast_acc && bus.cfg_chan == CW'(i)) begin
                cfg_d[i].en = bus.cfg_en;
            end
            if (commit && seq_ch_q == CW'(i)) begin
                cfg_d[i] = seq_cfg_q;
            end
            if (buf_wr && seq_ch_q == CW'(i)) begin
                buf_oe_d[i]  = seq_cfg_q.en;
                buf_dir_d[i] = seq_cfg_q.dir;
                buf_od_d[i]  = seq_cfg_q.od;
            end
            // The channel under sequencing keeps its FPGA driver off from acceptance until commit.
            pad_oe_d[i] = pad_oe_calc(cfg_q[i], bus.dout[i])
                          & ~((state_q != ST_IDLE) && (seq_ch_q == CW'(i)))
                          & ~(slow_acc && (bus.cfg_chan == CW'(i)));
            pad_dout_d[i] = ~cfg_q[i].od & bus.dout[i];
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q   <= ST_IDLE;
            cnt_q     <= '0;
            ready_q   <= 1'b0;
            seq_ch_q  <= '0;
            seq_cfg_q <= CFG_RESET;
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            ready_q   <= ready_d;
            seq_ch_q  <= seq_ch_d;
            seq_cfg_q <= seq_cfg_d;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cfg_q      <= {NCH{CFG_RESET}};
            pad_oe_q   <= '0;
            pad_dout_q <= '0;
            buf_oe_q   <= '0;
            buf_dir_q  <= '0;
            buf_od_q   <= '0;
        end else begin
            cfg_q      <= cfg_d;
            pad_oe_q   <= pad_oe_d;
            pad_dout_q <= pad_dout_d;
            buf_oe_q   <= buf_oe_d;
            buf_dir_q  <= buf_dir_d;
            buf_od_q   <= buf_od_d;
        end
    end

    iobuf_sync2 #(.W(NCH)) u_sync (
        .clk (clk),
        .rst (rst),
        .d_i (bus.pad_din),
        .q_o (din_sync_w)
    );

    assign bus.cfg_ready = ready_q;
    assign bus.din_sync  = din_sync_w;
    assign bus.pad_oe    = pad_oe_q;
    assign bus.pad_dout  = pad_dout_q;
    assign bus.buf_oe    = buf_oe_q;
    assign bus.buf_dir   = buf_dir_q;
    assign bus.buf_od    = buf_od_q;

endmodule
